// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types, register map and data helpers for the draw command master
package draw_pkg;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] attack_type;
    logic       player;
  } draw_cmd_t;

  localparam logic [2:0] ADDR_X      = 3'd0;
  localparam logic [2:0] ADDR_Y      = 3'd1;
  localparam logic [2:0] ADDR_TYPE   = 3'd2;
  localparam logic [2:0] ADDR_PLAYER = 3'd3;

  typedef enum logic [3:0] {
    IDLE,
    WR_X,
    WR_Y,
    WR_TYPE,
    WR_PLAYER,
    GAP,
    ARM,
    POLL,
    RETIRE
  } state_t;

  // Peripheral register address targeted by a write state
  function automatic logic [2:0] reg_addr(input state_t s);
    case (s)
      WR_Y:      return ADDR_Y;
      WR_TYPE:   return ADDR_TYPE;
      WR_PLAYER: return ADDR_PLAYER;
      default:   return ADDR_X;
    endcase
  endfunction

  // Zero-extended register payload for a write state; unused bits stay 0
  function automatic logic [7:0] reg_data(input state_t s, input draw_cmd_t c);
    case (s)
      WR_X:      return {4'b0, c.x};
      WR_Y:      return {4'b0, c.y};
      WR_TYPE:   return {6'b0, c.attack_type};
      WR_PLAYER: return {7'b0, c.player};
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// rtl/draw_cmd_fifo.sv - synchronous command queue of draw_cmd_t entries
import draw_pkg::*;

module draw_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  draw_cmd_t push_data,
  input  logic      pop,
  output draw_cmd_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  draw_cmd_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written only on an accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/draw_cmd_master.sv
// rtl/draw_cmd_master.sv - queues draw commands and replays them as register writes plus status poll (optional DRAW_TIMEOUT_EN)
import draw_pkg::*;

module draw_cmd_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int WR_GAP         = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_x,
  input  logic [3:0]  cmd_y,
  input  logic [1:0]  cmd_type,
  input  logic        cmd_player,
  output logic [2:0]  addr,
  output logic        wr_en,
  output logic        rd_en,
  output logic [7:0]  wr_data,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] draw_count,
  output logic        timeout_err
);

  localparam logic [7:0] GAP_LAST = 8'(WR_GAP - 1);

  draw_cmd_t cmd_in;
  draw_cmd_t fifo_head;
  draw_cmd_t cmd_q;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;
  state_t    state;
  state_t    gap_next;
  logic [7:0] gap_cnt;
  logic      to_hit;
  logic      rd_data_unused;

  assign cmd_in         = '{x: cmd_x, y: cmd_y, attack_type: cmd_type, player: cmd_player};
  assign cmd_ready      = !fifo_full;
  assign fifo_pop       = (state == IDLE) && !fifo_empty;
  assign rd_data_unused = ^rd_data[7:1];

  draw_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef DRAW_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;
  logic        waiting;

  assign waiting = (state == ARM) || (state == POLL);
  assign to_hit  = waiting && (to_cnt == TO_LAST);

  // Count cycles spent waiting on the peripheral; flag stays set until reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!waiting || to_hit) to_cnt <= '0;
      else                    to_cnt <= to_cnt + 1'b1;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign to_hit         = 1'b0;
  assign timeout_err    = 1'b0;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  // Registered busy: engine active or commands still queued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= 1'b0;
    else          busy <= (state != IDLE) || !fifo_empty;
  end

  // Sequencer: X, Y, TYPE, PLAYER writes separated by gaps, then wait for a fresh done
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gap_next   <= IDLE;
      gap_cnt    <= '0;
      cmd_q      <= '0;
      addr       <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      wr_data    <= '0;
      draw_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cmd_q   <= fifo_head;
            state   <= WR_X;
            wr_en   <= 1'b1;
            addr    <= ADDR_X;
            wr_data <= reg_data(WR_X, fifo_head);
          end
        end
        WR_X, WR_Y, WR_TYPE, WR_PLAYER: begin
          state   <= GAP;
          gap_cnt <= '0;
          wr_en   <= 1'b0;
          addr    <= ADDR_X;
          wr_data <= '0;
          case (state)
            WR_X:    gap_next <= WR_Y;
            WR_Y:    gap_next <= WR_TYPE;
            WR_TYPE: gap_next <= WR_PLAYER;
            default: gap_next <= ARM;
          endcase
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= gap_next;
            if (gap_next == ARM) begin
              rd_en <= 1'b1;
              addr  <= ADDR_X;
            end else begin
              wr_en   <= 1'b1;
              addr    <= reg_addr(gap_next);
              wr_data <= reg_data(gap_next, cmd_q);
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ARM: begin
          // a done still high from the previous draw is not ours
          if (to_hit) begin
            state <= IDLE;
            rd_en <= 1'b0;
          end else if (!rd_data[0]) begin
            state <= POLL;
          end
        end
        POLL: begin
          if (to_hit) begin
            state <= IDLE;
            rd_en <= 1'b0;
          end else if (rd_data[0]) begin
            state <= RETIRE;
            rd_en <= 1'b0;
          end
        end
        RETIRE: begin
          draw_count <= draw_count + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_master.sv
// tb/tb_draw_cmd_master.sv - directed self-checking bench for draw_cmd_master
module tb_draw_cmd_master;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_x;
  logic [3:0]  cmd_y;
  logic [1:0]  cmd_type;
  logic        cmd_player;
  logic [2:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        busy;
  logic [15:0] draw_count;
  logic        timeout_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int both_cnt = 0;
  int idle_bad = 0;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;
  wr_t wlog[$];

  draw_cmd_master #(
    .FIFO_DEPTH     (4),
    .WR_GAP         (2),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_type    (cmd_type),
    .cmd_player  (cmd_player),
    .addr        (addr),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .busy        (busy),
    .draw_count  (draw_count),
    .timeout_err (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Bus monitor: log writes and track strobe/idle-bus rule violations
  always @(negedge clock) begin
    if (wr_en) wlog.push_back('{addr, wr_data, cyc});
    if (wr_en && rd_en) both_cnt++;
    if (!wr_en && !rd_en && (addr != 3'd0 || wr_data != 8'd0)) idle_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic push_cmd(input logic [3:0] x, input logic [3:0] y,
                          input logic [1:0] t, input logic p);
    int n = 0;
    step();
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_type = t; cmd_player = p;
    while (cmd_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL push_wait: cmd_ready stayed %b, required 1", cmd_ready);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int bound);
    int k = 0;
    while (wlog.size() < n && k < bound) begin
      step();
      k++;
    end
    if (wlog.size() < n) begin
      total_cnt++;
      $display("FAIL log_wait: saw %0d writes, required %0d", wlog.size(), n);
    end
  endtask

  task automatic wait_rd_en(input int bound);
    int k = 0;
    while (rd_en !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    if (rd_en !== 1'b1) begin
      total_cnt++;
      $display("FAIL rd_en_wait: rd_en=%b, required 1", rd_en);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({addr, wr_en, rd_en, wr_data} !== 13'd0) $display("FAIL reset_bus: got %h required 0", {addr, wr_en, rd_en, wr_data});
    else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if ({busy, draw_count, timeout_err} !== 18'd0) $display("FAIL reset_status: got %h required 0", {busy, draw_count, timeout_err});
    else pass_cnt++;
    reset_n = 1'b1;
    repeat (2) step();
    total_cnt++;
    if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) $display("FAIL reset_idle: wr_en=%b rd_en=%b busy=%b required 0", wr_en, rd_en, busy);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int bad = 0;
    logic [2:0] ea [4];
    logic [7:0] ed [4];
    ea = '{3'd0, 3'd1, 3'd2, 3'd3};
    ed = '{8'h05, 8'h09, 8'h02, 8'h01};
    rd_data = 8'h00;
    wlog.delete();
    push_cmd(4'd5, 4'd9, 2'd2, 1'b1);
    wait_log(4, 60);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wlog.size() || wlog[i].a !== ea[i] || wlog[i].d !== ed[i])
        $display("FAIL single_write%0d: got addr/data %0d/%h required %0d/%h", i,
                 (i < wlog.size()) ? wlog[i].a : 3'd7, (i < wlog.size()) ? wlog[i].d : 8'hxx, ea[i], ed[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (i + 1 >= wlog.size() || wlog[i+1].c - wlog[i].c != 3)
        $display("FAIL single_spacing%0d: got %0d cycles required 3", i,
                 (i + 1 < wlog.size()) ? wlog[i+1].c - wlog[i].c : -1);
      else pass_cnt++;
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i <= 2 && rd_en !== 1'b0) bad++;
      if (i >= 3 && rd_en !== 1'b1) bad++;
      if (i == 20) rd_data = 8'h01;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL single_rd_en_hold: got %0d bad cycles required 0", bad);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rd_en !== 1'b0 || draw_count !== 16'd0) $display("FAIL single_retire: rd_en=%b draw_count=%0d required 0/0", rd_en, draw_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (draw_count !== 16'd1 || busy !== 1'b1) $display("FAIL single_count: draw_count=%0d busy=%b required 1/1", draw_count, busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_queue_full();
    int bad = 0;
    int k = 0;
    do_reset();
    rd_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_ready !== 1'b1) bad++;
      cmd_valid = 1'b1; cmd_x = 4'(i + 1); cmd_y = 4'd0; cmd_type = 2'd0; cmd_player = 1'b0;
    end
    step();
    total_cnt++;
    if (bad != 0) $display("FAIL full_accept: got %0d refusals required 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL full_ready_low: got %b required 0", cmd_ready);
    else pass_cnt++;
    cmd_x = 4'd6;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cmd_ready !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0 || busy !== 1'b1 || rd_en !== 1'b1) $display("FAIL full_hold: ready-high cycles=%0d busy=%b rd_en=%b required 0/1/1", bad, busy, rd_en);
    else pass_cnt++;
    rd_data = 8'h01;
    wlog.delete();
    while (cmd_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    total_cnt++;
    if (cmd_ready !== 1'b1 || draw_count !== 16'd1) $display("FAIL full_release: cmd_ready=%b draw_count=%0d required 1/1", cmd_ready, draw_count);
    else pass_cnt++;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    wait_log(1, 20);
    total_cnt++;
    if (wlog.size() < 1 || wlog[0].a !== 3'd0 || wlog[0].d !== 8'h02)
      $display("FAIL full_next_head: got addr/data %0d/%h required 0/02",
               (wlog.size() > 0) ? wlog[0].a : 3'd7, (wlog.size() > 0) ? wlog[0].d : 8'hxx);
    else pass_cnt++;
  endtask

  task automatic test_stale_done();
    int bad = 0;
    int k = 0;
    do_reset();
    rd_data = 8'h01;
    push_cmd(4'd3, 4'd4, 2'd1, 1'b0);
    wait_rd_en(60);
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_en !== 1'b1 || draw_count !== 16'd0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL stale_no_retire: got %0d bad cycles required 0", bad);
    else pass_cnt++;
    rd_data = 8'h00;
    repeat (3) step();
    rd_data = 8'h01;
    while (draw_count === 16'd0 && k < 20) begin
      step();
      k++;
    end
    total_cnt++;
    if (draw_count !== 16'd1) $display("FAIL stale_retire: got %0d required 1", draw_count);
    else pass_cnt++;
    repeat (10) step();
    total_cnt++;
    if (draw_count !== 16'd1) $display("FAIL stale_once: got %0d required 1", draw_count);
    else pass_cnt++;
  endtask

  task automatic test_masking();
    int k = 0;
    logic [7:0] ed [4];
    ed = '{8'h0F, 8'h00, 8'h03, 8'h00};
    rd_data = 8'h00;
    wlog.delete();
    push_cmd(4'd15, 4'd0, 2'd3, 1'b0);
    wait_log(4, 60);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wlog.size() || wlog[i].a !== 3'(i) || wlog[i].d !== ed[i])
        $display("FAIL mask_write%0d: got addr/data %0d/%h required %0d/%h", i,
                 (i < wlog.size()) ? wlog[i].a : 3'd7, (i < wlog.size()) ? wlog[i].d : 8'hxx, i, ed[i]);
      else pass_cnt++;
    end
    repeat (5) step();
    rd_data = 8'h01;
    while (draw_count !== 16'd2 && k < 30) begin
      step();
      k++;
    end
    total_cnt++;
    if (draw_count !== 16'd2) $display("FAIL mask_retire: got %0d required 2", draw_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    int bad = 0;
    rd_data = 8'h00;
    wlog.delete();
    push_cmd(4'd1, 4'd2, 2'd1, 1'b1);
    push_cmd(4'd7, 4'd8, 2'd2, 1'b0);
    push_cmd(4'd9, 4'd10, 2'd3, 1'b1);
    wait_log(3, 60);
    step();
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({addr, wr_en, rd_en, wr_data} !== 13'd0 || cmd_ready !== 1'b1)
      $display("FAIL midreset_bus: got %h ready=%b required 0/1", {addr, wr_en, rd_en, wr_data}, cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || draw_count !== 16'd0) $display("FAIL midreset_status: busy=%b draw_count=%0d required 0/0", busy, draw_count);
    else pass_cnt++;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0 || draw_count !== 16'd0) $display("FAIL midreset_idle: active cycles=%0d draw_count=%0d required 0/0", bad, draw_count);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    rd_data = 8'h00;
    push_cmd(4'd4, 4'd1, 2'd0, 1'b0);
    push_cmd(4'd11, 4'd2, 2'd1, 1'b1);
    wait_rd_en(60);
`ifdef DRAW_TIMEOUT_EN
    while (rd_en === 1'b1 && n < 200) begin
      n++;
      step();
    end
    wlog.delete();
    total_cnt++;
    if (n != 50) $display("FAIL timeout_cycles: got %0d poll cycles required 50", n);
    else pass_cnt++;
    total_cnt++;
    if (timeout_err !== 1'b1 || draw_count !== 16'd0) $display("FAIL timeout_flag: timeout_err=%b draw_count=%0d required 1/0", timeout_err, draw_count);
    else pass_cnt++;
    wait_log(1, 20);
    total_cnt++;
    if (wlog.size() < 1 || wlog[0].a !== 3'd0 || wlog[0].d !== 8'h0B)
      $display("FAIL timeout_next: got addr/data %0d/%h required 0/0b",
               (wlog.size() > 0) ? wlog[0].a : 3'd7, (wlog.size() > 0) ? wlog[0].d : 8'hxx);
    else pass_cnt++;
    repeat (20) step();
    total_cnt++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", timeout_err);
    else pass_cnt++;
`else
    while (rd_en === 1'b1 && n < 100) begin
      n++;
      step();
    end
    total_cnt++;
    if (n != 100 || timeout_err !== 1'b0 || draw_count !== 16'd0)
      $display("FAIL no_timeout_wait: poll cycles=%0d timeout_err=%b draw_count=%0d required 100/0/0", n, timeout_err, draw_count);
    else pass_cnt++;
`endif
  endtask

  task automatic test_bus_rules();
    total_cnt++;
    if (both_cnt != 0) $display("FAIL bus_both_strobes: got %0d cycles required 0", both_cnt);
    else pass_cnt++;
    total_cnt++;
    if (idle_bad != 0) $display("FAIL bus_idle_zero: got %0d cycles required 0", idle_bad);
    else pass_cnt++;
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_x      = 4'd0;
    cmd_y      = 4'd0;
    cmd_type   = 2'd0;
    cmd_player = 1'b0;
    rd_data    = 8'h00;
    test_reset();
    test_single();
    test_queue_full();
    test_stale_done();
    test_masking();
    test_reset_mid_write();
    test_timeout();
    test_bus_rules();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/draw_cmd_master.md
Name: draw_cmd_master

Overview:
- Bus initiator that drives the draw peripheral's register write/read interface (addr/wr_en/rd_en/data).
- Game-side logic pushes draw commands (x, y, attack type, player) through a valid/ready handshake into a small FIFO.
- The block serialises each command into the fixed register write sequence X, Y, TYPE, PLAYER (the PLAYER write triggers the draw). It then polls the status byte until the draw completes and retires the command.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, at least 2.
- WR_GAP, 2, idle bus cycles inserted after every write and before the first poll. The peripheral's state register lags one extra cycle, so the minimum legal value is 2.
- TIMEOUT_CYCLES, 65535, poll cycles allowed before abort; used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept
- cmd_x  in  4  column 0..15
- cmd_y  in  4  row 0..15
- cmd_type  in  2  attack/hit type
- cmd_player  in  1  target board
- addr  out  3  peripheral register address
- wr_en  out  1  write strobe, one cycle per write
- rd_en  out  1  status read strobe
- wr_data  out  8  write data
- rd_data  in  8  peripheral status; bit0 = draw done
- busy  out  1  engine not IDLE or queue non-empty
- draw_count  out  16  retired commands, wraps at 0xFFFF->0
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values: all outputs 0, except `cmd_ready` = 1 (queue empty). Queue empty, state IDLE.
- Handshake:
  - A push occurs when `cmd_valid` && `cmd_ready` on a clock edge.
  - `cmd_ready` = !full. A pop in the same cycle does not raise it.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Register map:
  - addr 0 = X, wr_data = {4'b0, x}
  - addr 1 = Y, wr_data = {4'b0, y}
  - addr 2 = TYPE, wr_data = {6'b0, type}
  - addr 3 = PLAYER, wr_data = {7'b0, player}
  - Unused wr_data bits are always 0.
- FSM states: IDLE, WR_X, WR_Y, WR_TYPE, WR_PLAYER, GAP, ARM, POLL, RETIRE.
  - IDLE: if the queue is non-empty, pop the head into the command register and go to WR_X. Command-to-first-write latency from IDLE is 1 cycle.
  - WR_* states: drive `addr`/`wr_data` with `wr_en`=1 for exactly one cycle, then go to GAP. GAP counts WR_GAP cycles, then advances to the next write state. After WR_PLAYER, GAP advances to ARM.
  - ARM: `rd_en`=1, addr=0. Wait for `rd_data[0]`==0, which rejects a stale done from the previous draw, then go to POLL.
  - POLL: `rd_en`=1, addr=0. When `rd_data[0]`==1, go to RETIRE.
  - RETIRE: one cycle; `draw_count` increments; return to IDLE.
- Bus strobes: `wr_en` and `rd_en` are never both 1. In GAP and IDLE, addr = 0 and wr_data = 0.
- Addr-0 restart: the X write is always first, so it also restarts the peripheral out of its done state.
- `busy` is registered and reflects state at the previous edge.
- Reset mid-operation: everything returns to reset values and queued commands are discarded. The peripheral must be reset in the same cycle; this block has no recovery handshake.

Optional Feature:
- DRAW_TIMEOUT_EN defined:
  - A 16-bit counter runs in ARM+POLL.
  - On reaching TIMEOUT_CYCLES: `timeout_err` is set (sticky until reset), the command is dropped without incrementing `draw_count`, and the FSM goes to IDLE.
- DRAW_TIMEOUT_EN undefined: no counter, ARM/POLL wait forever, and `timeout_err` is tied to 0.

Decomposition:
- Package draw_pkg:
  - typedef draw_cmd_t struct {x[3:0], y[3:0], attack_type[1:0], player}
  - localparams ADDR_X=0, ADDR_Y=1, ADDR_TYPE=2, ADDR_PLAYER=3
  - state enum
- Sub-module draw_cmd_fifo: synchronous FIFO of draw_cmd_t with push/pop/full/empty, parameterised on FIFO_DEPTH.

Test Plan:
- Single command: push x=5, y=9, type=2, player=1; responder raises rd_data[0] 20 cycles after the PLAYER write.
  -> Writes (addr, data) appear in order: (0,0x05), (1,0x09), (2,0x02), (3,0x01), each one cycle wide with exactly 2 idle cycles between them.
  -> rd_en is held until done; draw_count=1; busy drops after RETIRE.
- Queue full: rd_data held 0; push 6 commands back to back.
  -> The first is popped and 4 are queued.
  -> cmd_ready=0 while the 6th is offered; it is accepted only after the first retires.
- Stale done: rd_data[0]=1 at start of ARM.
  -> No retire until rd_data is seen 0 and then 1; draw_count increments exactly once.
- Masking: push x=15, y=0, type=3, player=0.
  -> wr_data = 0x0F, 0x00, 0x03, 0x00; upper bits are zero.
- Reset mid-write: assert reset_n=0 during the WR_TYPE GAP with 2 commands queued.
  -> Outputs immediately go to reset values; after release the bus stays idle and draw_count=0.
- DRAW_TIMEOUT_EN with TIMEOUT_CYCLES=50 and rd_data stuck 0.
  -> timeout_err=1 after 50 poll cycles; draw_count unchanged; the next queued command starts with an addr-0 write.
